// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sap_pkg
// Brief    : SAP-1 opcodes, one-hot T-state encodings and control-word bit
//            indices shared by the control unit, IR and datapath.
// Revision : 1.0
// ============================================================================
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned T_WIDTH = 6;
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam int unsigned CW_CP    = 0;
  localparam int unsigned CW_EP    = 1;
  localparam int unsigned CW_LM    = 2;
  localparam int unsigned CW_CE    = 3;
  localparam int unsigned CW_LI    = 4;
  localparam int unsigned CW_EI    = 5;
  localparam int unsigned CW_LA    = 6;
  localparam int unsigned CW_EA    = 7;
  localparam int unsigned CW_SU    = 8;
  localparam int unsigned CW_EU    = 9;
  localparam int unsigned CW_LB    = 10;
  localparam int unsigned CW_LO    = 11;
  localparam int unsigned CW_WIDTH = 12;

  // Opcodes with a defined execute phase; everything else runs as a NOP.
  function automatic logic is_defined_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage : sap_pkg
`default_nettype wire

// File: rtl/sap_ring_counter.sv
`default_nettype none
// ============================================================================
// Module   : sap_ring_counter
// Brief    : One-hot T1..T6 ring with sync reset, sticky halt and early wrap.
// Revision : 1.0
// ============================================================================
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_halt,
  input  logic                 i_wrap,
  output logic [T_WIDTH-1:0]   o_tstate,
  output logic                 o_halted
);

  logic [T_WIDTH-1:0] ring_q, ring_d;
  logic               halted_q, halted_d;

  // Once halted the ring is frozen; only reset restarts it.
  always_comb begin
    ring_d   = ring_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (i_halt) begin
        halted_d = 1'b1;
      end else if (i_wrap || ring_q[T_WIDTH-1]) begin
        ring_d = T1;
      end else begin
        ring_d = {ring_q[T_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q   <= T1;
      halted_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      halted_q <= halted_d;
    end
  end

  assign o_tstate = halted_q ? '0 : ring_q;
  assign o_halted = halted_q;

endmodule : sap_ring_counter
`default_nettype wire

// File: rtl/sap_controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sap_controller_sequencer
// Brief    : SAP-1 control unit: T-state ring plus opcode decoder driving the
//            control word. Optional SAP_CTRL_SKIP_NOP_EN shortens the machine
//            cycle of LDA, OUT and undefined opcodes.
// Revision : 1.0
// ============================================================================
module sap_controller_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  output logic [5:0]              o_tstate,
  output logic                    o_pc_increment,
  output logic                    o_pc_enable_out,
  output logic                    o_mar_enable_in,
  output logic                    o_ram_enable_out,
  output logic                    o_ir_enable_in,
  output logic                    o_ir_enable_out,
  output logic                    o_a_enable_in,
  output logic                    o_a_enable_out,
  output logic                    o_alu_subtract,
  output logic                    o_alu_enable_out,
  output logic                    o_b_enable_in,
  output logic                    o_out_enable_in,
  output logic                    o_halt
);

  logic [T_WIDTH-1:0]  w_tstate;
  logic                w_halted;
  logic                w_halt_req;
  logic                w_wrap;
  logic [CW_WIDTH-1:0] w_cw;

  sap_ring_counter u_ring (
    .clk      (i_clock),
    .rst      (i_reset),
    .i_halt   (w_halt_req),
    .i_wrap   (w_wrap),
    .o_tstate (w_tstate),
    .o_halted (w_halted)
  );

  // w_tstate is zero while halted, so no state branch fires then.
  always_comb begin
    w_cw       = '0;
    w_halt_req = 1'b0;
    w_wrap     = 1'b0;

    if (w_tstate[0]) begin
      w_cw[CW_EP] = 1'b1;
      w_cw[CW_LM] = 1'b1;
    end

    if (w_tstate[1]) begin
      w_cw[CW_CP] = 1'b1;
    end

    if (w_tstate[2]) begin
      w_cw[CW_CE] = 1'b1;
      w_cw[CW_LI] = 1'b1;
`ifdef SAP_CTRL_SKIP_NOP_EN
      if (!is_defined_op(4'(i_opcode))) w_wrap = 1'b1;
`endif
    end

    if (w_tstate[3]) begin
      case (4'(i_opcode))
        OP_LDA, OP_ADD, OP_SUB: begin
          w_cw[CW_EI] = 1'b1;
          w_cw[CW_LM] = 1'b1;
        end
        OP_OUT: begin
          w_cw[CW_EA] = 1'b1;
          w_cw[CW_LO] = 1'b1;
`ifdef SAP_CTRL_SKIP_NOP_EN
          w_wrap      = 1'b1;
`endif
        end
        OP_HLT:  w_halt_req = 1'b1;
        default: ;
      endcase
    end

    if (w_tstate[4]) begin
      case (4'(i_opcode))
        OP_LDA: begin
          w_cw[CW_CE] = 1'b1;
          w_cw[CW_LA] = 1'b1;
`ifdef SAP_CTRL_SKIP_NOP_EN
          w_wrap      = 1'b1;
`endif
        end
        OP_ADD, OP_SUB: begin
          w_cw[CW_CE] = 1'b1;
          w_cw[CW_LB] = 1'b1;
        end
        default: ;
      endcase
    end

    if (w_tstate[5]) begin
      case (4'(i_opcode))
        OP_ADD: begin
          w_cw[CW_EU] = 1'b1;
          w_cw[CW_LA] = 1'b1;
        end
        OP_SUB: begin
          w_cw[CW_SU] = 1'b1;
          w_cw[CW_EU] = 1'b1;
          w_cw[CW_LA] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_tstate         = w_tstate;
  assign o_pc_increment   = w_cw[CW_CP];
  assign o_pc_enable_out  = w_cw[CW_EP];
  assign o_mar_enable_in  = w_cw[CW_LM];
  assign o_ram_enable_out = w_cw[CW_CE];
  assign o_ir_enable_in   = w_cw[CW_LI];
  assign o_ir_enable_out  = w_cw[CW_EI];
  assign o_a_enable_in    = w_cw[CW_LA];
  assign o_a_enable_out   = w_cw[CW_EA];
  assign o_alu_subtract   = w_cw[CW_SU];
  assign o_alu_enable_out = w_cw[CW_EU];
  assign o_b_enable_in    = w_cw[CW_LB];
  assign o_out_enable_in  = w_cw[CW_LO];
  assign o_halt           = w_halted | w_halt_req;

endmodule : sap_controller_sequencer
`default_nettype wire
